flash_rd_arbiter: RTL

//  Shares the single word-read req/ack port of the flash controller between two requesters.

---
 rtl/flash_rd_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/flash_rd_arbiter.sv
// flash_rd_arbiter: shares the flash controller's single word-read
// req/ack port between port A (ROM loader) and port B (aux reader).
//
// Ports:
//   iclk, ireset        clock, synchronous active-high reset
//   ia_addr/ia_req      port A request (level), address stable while req
//   oa_data/oa_ack      port A read data, 1-cycle completion pulse
//   ib_addr/ib_req      port B request (level)
//   ob_data/ob_ack      port B read data, 1-cycle completion pulse
//   ofl_addr/ofl_req    request to flash controller (level)
//   ifl_data/ifl_ack    flash read data, 1-cycle completion pulse
//   ogrant              {B,A} one-hot owner of the current read
//   otimeout            pulse when the watchdog aborts a read
module flash_rd_arbiter #(
    parameter int AW      = 23,
    parameter int DW      = 16,
    parameter int TIMEOUT = 1023,
    parameter int FIXED_A = 0
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic [AW-1:0] ia_addr,
    input  logic          ia_req,
    output logic [DW-1:0] oa_data,
    output logic          oa_ack,
    input  logic [AW-1:0] ib_addr,
    input  logic          ib_req,
    output logic [DW-1:0] ob_data,
    output logic          ob_ack,
    output logic [AW-1:0] ofl_addr,
    output logic          ofl_req,
    input  logic [DW-1:0] ifl_data,
    input  logic          ifl_ack,
    output logic [1:0]    ogrant,
    output logic          otimeout
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wdog_q, wdog_d;
    // 1: port B was served last (so A wins the next tie)
    logic          last_b_q, last_b_d;
    // 1: port B owns the read in flight
    logic          own_b_q, own_b_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic [1:0]    grant_q, grant_d;
    logic [DW-1:0] a_data_q, a_data_d;
    logic [DW-1:0] b_data_q, b_data_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic          tmo_q, tmo_d;

    logic          pick_b;
    logic          expire;
    logic [DW-1:0] rd_word;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            last_b_q <= 1'b1;
            own_b_q  <= 1'b0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            grant_q  <= 2'b00;
            a_data_q <= '0;
            b_data_q <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            last_b_q <= last_b_d;
            own_b_q  <= own_b_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            grant_q  <= grant_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        pick_b = 1'b0;
        unique case (1'b1)
            (ib_req && !ia_req): pick_b = 1'b1;
            (ib_req && ia_req):  pick_b = (FIXED_A == 0) && !last_b_q;
            default:             pick_b = 1'b0;
        endcase
    end

    assign expire  = (wdog_q == WW'(TIMEOUT - 1));
    // An abort returns all-ones so the requester sees a defined word.
    assign rd_word = ifl_ack ? ifl_data : {DW{1'b1}};

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        last_b_d = last_b_q;
        own_b_d  = own_b_q;
        addr_d   = addr_q;
        req_d    = req_q;
        grant_d  = grant_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        tmo_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (ia_req || ib_req) begin
                    own_b_d = pick_b;
                    addr_d  = pick_b ? ib_addr : ia_addr;
                    grant_d = pick_b ? 2'b10 : 2'b01;
                    req_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                wdog_d = wdog_q + 1'b1;
                // ack has priority over a same-cycle watchdog expiry
                if (ifl_ack || expire) begin
                    req_d   = 1'b0;
                    grant_d = 2'b00;
                    tmo_d   = !ifl_ack;
                    state_d = S_DONE;
                    if (own_b_q) begin
                        b_data_d = rd_word;
                        b_ack_d  = 1'b1;
                    end else begin
                        a_data_d = rd_word;
                        a_ack_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                last_b_d = own_b_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ofl_addr = addr_q;
    assign ofl_req  = req_q;
    assign ogrant   = grant_q;
    assign oa_data  = a_data_q;
    assign oa_ack   = a_ack_q;
    assign ob_data  = b_data_q;
    assign ob_ack   = b_ack_q;
    assign otimeout = tmo_q;

endmodule
